alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, arbiter state encoding and request payload type.
// Used by the arbiter front-end and by the ALU itself.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SLA = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
    } alu_req_t;

    // 1100-1111 fall through as plain ALU ops
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester not granted most recently wins. Pointer moves only on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q;  // index that wins a tie

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) grant[prio_q] = 1'b1;
            else                grant = valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio_q <= 1'b0;
        else if (|grant) prio_q <= grant[0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation in flight.
// LW/SW hold the ALU drive for MEM_LAT extra cycles before the response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_opcode,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_opcode,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q;
    logic [1:0] grant;
    alu_req_t   req0, req1, sel;

    assign req0 = '{opcode: req0_opcode, a: req0_a, b: req0_b};
    assign req1 = '{opcode: req1_opcode, a: req1_a, b: req1_b};
    assign sel  = grant[1] ? req1 : req0;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_IDLE),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = (state_q == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|grant) state_d = ST_EXEC;
            ST_EXEC: state_d = is_mem_op(alu_opcode) ? ST_MEM : ST_RESP;
            ST_MEM:  if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU drive is loaded only on a grant, so it stays put through RESP and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {alu_opcode, alu_a, alu_b} <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= 4'd0;
            cnt_q    <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (|grant) begin
                    {alu_opcode, alu_a, alu_b} <= sel;
                    rsp_id <= grant[1];
                end
                ST_EXEC: begin
                    if (is_mem_op(alu_opcode)) cnt_q    <= LAT_M1;
                    else                       rsp_data <= alu_result;
                end
                ST_MEM: begin
                    if (cnt_q == 4'd0)
                        rsp_data <= (alu_opcode == OP_SW) ? 4'd0 : alu_result;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU/memory
// on the shared port and a transaction-level expectation model.
module tb_alu_arbiter;

    localparam int MEM_LAT = 3;

    logic       clk, rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b;
    logic [3:0] alu_opcode, alu_a, alu_b, alu_result;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_data;
    logic [3:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; LW reads the memory word, SW returns a so that a
    // forgotten zeroing would be visible.
    function automatic logic [3:0] alu_model(input logic [3:0] op, a, b, mem);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << b[1:0];
            4'd7:    return a >> b[1:0];
            4'd8:    return a << 1;
            4'd9:    return 4'($signed(a) >>> b[1:0]);
            4'd10:   return mem;
            4'd11:   return a;
            default: return a ^ b ^ op;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_opcode, alu_a, alu_b, mem_data);

    function automatic logic [3:0] exp_data(input logic [3:0] op, a, b, mem);
        return (op == 4'd11) ? 4'd0 : alu_model(op, a, b, mem);
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (op == 4'd10 || op == 4'd11) ? 2 + MEM_LAT : 2;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [3:0] op, a, b);
        if (id) begin
            req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one op from a single requester (caller at a negedge) and collect
    // accept-to-rsp_valid latency, response fields and ALU-drive stability.
    task automatic issue(input bit id, input logic [3:0] op, a, b,
                         output int lat, output logic rid, output logic [3:0] rdata,
                         output bit held, output bit tmo);
        int w;
        w = 0; lat = 0; held = 1'b1; tmo = 1'b0; rid = 1'b0; rdata = 4'd0;
        set_req(id, 1'b1, op, a, b);
        #1;
        while (!(id ? req1_ready : req0_ready)) begin
            if (w >= 40) begin tmo = 1'b1; set_req(id, 1'b0, op, a, b); return; end
            tick(); #1; w++;
        end
        tick();
        set_req(id, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        lat = 1;
        while (!rsp_valid) begin
            if ({alu_opcode, alu_a, alu_b} !== {op, a, b}) held = 1'b0;
            if (lat >= 60) begin tmo = 1'b1; return; end
            tick(); #1; lat++;
        end
        if ({alu_opcode, alu_a, alu_b} !== {op, a, b}) held = 1'b0;
        rid = rsp_id; rdata = rsp_data;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got op=%h a=%h b=%h v=%b id=%b d=%h, want all 0",
                     alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data);
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_basic();
        int lat; logic rid; logic [3:0] rd; bit held, tmo;
        issue(1'b0, 4'd0, 4'd3, 4'd4, lat, rid, rd, held, tmo);
        n_checks++;
        if (tmo || lat !== 2 || rid !== 1'b0 || rd !== 4'b0111 || !held) begin
            n_fail++;
            $display("FAIL add_basic: tmo=%0b lat=%0d id=%b data=%b held=%0b, want lat=2 id=0 data=0111 held=1",
                     tmo, lat, rid, rd, held);
        end
        issue(1'b0, 4'd1, 4'b0001, 4'b0010, lat, rid, rd, held, tmo);
        n_checks++;
        if (tmo || lat !== 2 || rd !== 4'b1111) begin
            n_fail++;
            $display("FAIL sub_wrap: tmo=%0b lat=%0d data=%b, want lat=2 data=1111", tmo, lat, rd);
        end
    endtask

    task automatic test_mem_ops();
        int lat; logic rid; logic [3:0] rd; bit held, tmo;
        mem_data = 4'b1010;
        issue(1'b1, 4'd10, 4'd2, 4'd5, lat, rid, rd, held, tmo);
        n_checks++;
        if (tmo || lat !== 5 || rid !== 1'b1 || rd !== 4'b1010 || !held) begin
            n_fail++;
            $display("FAIL lw: tmo=%0b lat=%0d id=%b data=%b held=%0b, want lat=5 id=1 data=1010 held=1",
                     tmo, lat, rid, rd, held);
        end
        issue(1'b1, 4'd11, 4'd7, 4'd6, lat, rid, rd, held, tmo);
        n_checks++;
        if (tmo || lat !== 5 || rid !== 1'b1 || rd !== 4'b0000) begin
            n_fail++;
            $display("FAIL sw: tmo=%0b lat=%0d id=%b data=%b, want lat=5 id=1 data=0000",
                     tmo, lat, rid, rd);
        end
    endtask

    task automatic test_random();
        int lat; logic rid; logic [3:0] rd; bit held, tmo;
        bit id; logic [3:0] op, a, b;
        for (int i = 0; i < 24; i++) begin
            id = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            mem_data = 4'($urandom_range(0, 15));
            issue(id, op, a, b, lat, rid, rd, held, tmo);
            n_checks++;
            if (tmo || lat !== exp_lat(op) || rid !== id || rd !== exp_data(op, a, b, mem_data) || !held) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: tmo=%0b lat=%0d id=%b data=%h held=%0b, want lat=%0d id=%b data=%h",
                         i, op, a, b, tmo, lat, rid, rd, held, exp_lat(op), id, exp_data(op, a, b, mem_data));
            end
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_ptr;
        do_reset();
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 4'd0, 4'd1, 4'd1);
        set_req(1'b1, 1'b1, 4'd2, 4'd3, 4'd6);
        #1;
        for (int c = 0; c < 16; c++) begin
            if (req0_ready && req1_ready) begin
                n_checks++; n_fail++;
                $display("FAIL rr_both_ready: cycle %0d got 11, want one-hot", c);
            end
            if (req0_ready) got.push_back(0);
            if (req1_ready) got.push_back(1);
            tick(); #1;
        end
        set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d, want 6", got.size());
        end
        exp_ptr = 0;
        foreach (got[k]) begin
            n_checks++;
            if (got[k] != exp_ptr) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d, want %0d", k, got[k], exp_ptr);
            end
            exp_ptr = 1 - exp_ptr;
        end
        repeat (4) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_single_requester();
        int lat; logic rid; logic [3:0] rd; bit held, tmo;
        int w;
        do_reset();
        issue(1'b0, 4'd0, 4'd1, 4'd2, lat, rid, rd, held, tmo);
        issue(1'b0, 4'd0, 4'd2, 4'd2, lat, rid, rd, held, tmo);
        n_checks++;
        if (tmo || rid !== 1'b0 || rd !== 4'd4) begin
            n_fail++;
            $display("FAIL single_req_regrant: tmo=%0b id=%b data=%h, want id=0 data=4", tmo, rid, rd);
        end
        // last grant went to 0, so a tie now goes to requester 1
        set_req(1'b0, 1'b1, 4'd0, 4'd1, 4'd1);
        set_req(1'b1, 1'b1, 4'd4, 4'd5, 4'd3);
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_after_req0: got %b, want 10", {req1_ready, req0_ready});
        end
        tick();
        set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        w = 0;
        #1;
        while (!rsp_valid && w < 30) begin tick(); #1; w++; end
        n_checks++;
        if (!rsp_valid || rsp_id !== 1'b1 || rsp_data !== 4'd6) begin
            n_fail++;
            $display("FAIL tie_rsp: valid=%b id=%b data=%h, want 1 1 6", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int w;
        set_req(1'b0, 1'b1, 4'd0, 4'd5, 4'd6);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got %b, want 1", req0_ready);
        end
        tick();
        set_req(1'b0, 1'b1, 4'd4, 4'd9, 4'd3);
        tick(); #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'hB || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: v=%b id=%b d=%h rdy=%b, want 1 0 b 0",
                         c, rsp_valid, rsp_id, rsp_data, req0_ready);
            end
            tick(); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_cycle: rdy=%b v=%b, want 0 1", req0_ready, rsp_valid);
        end
        tick();
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_grant: rdy=%b v=%b, want 1 0", req0_ready, rsp_valid);
        end
        tick();
        set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        w = 0;
        #1;
        while (!rsp_valid && w < 30) begin tick(); #1; w++; end
        n_checks++;
        if (!rsp_valid || rsp_data !== 4'hA) begin
            n_fail++;
            $display("FAIL bp_second_rsp: v=%b d=%h, want 1 a", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        mem_data = 4'hD;
        set_req(1'b1, 1'b1, 4'd10, 4'd5, 4'd9);
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mem_accept: got %b, want 1", req1_ready);
        end
        tick();
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_mem_outputs: op=%h a=%h b=%h v=%b id=%b d=%h, want all 0",
                     alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_data);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(); #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mem_stale[%0d]: rsp_valid=%b, want 0", c, rsp_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        mem_data = 4'd0;
        set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_add_basic();
        test_mem_ops();
        test_random();
        test_round_robin();
        test_single_requester();
        test_backpressure();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
